// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, 3-sample majority vote and a show-ahead
// RX FIFO carrying per-entry parity/framing flags behind a valid/ready port.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_perr,
    output logic                          m_ferr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          busy
);

    localparam int DIV   = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_BITS + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 prev_q, prev_d;
    logic [2:0]           state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           tick_q, tick_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_q, bit_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [PTR_W-1:0]     wr_q, wr_d;
    logic [PTR_W-1:0]     rd_q, rd_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];

    logic             rx_s;
    logic             start_edge;
    logic             tick;
    logic             maj;
    logic             mid;
    logic             bit_end;
    logic             full;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    assign rx_s       = sync2_q;
    assign start_edge = (state_q == S_IDLE) && prev_q && !rx_s;
    assign tick       = (div_q == DIV_W'(DIV - 1));
    assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) |
                        (smp_q[1] & rx_s);
    assign mid        = tick && (tick_q == 4'd9);
    assign bit_end    = tick && (tick_q == 4'd15);

    // Input synchroniser, edge history and bit-timing counters
    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
        prev_d  = rx_s;
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        tick_d  = tick_q;
        smp_d   = smp_q;
        if (start_edge) begin
            div_d  = '0;
            tick_d = '0;
        end else if (state_q != S_IDLE && tick) begin
            tick_d = tick_q + 4'd1;
            if (tick_q == 4'd7) begin
                smp_d[0] = rx_s;
            end
            if (tick_q == 4'd8) begin
                smp_d[1] = rx_s;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_START;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (mid && maj) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PAR: begin
                if (mid) begin
                    // Odd parity wants data^par == 1, even wants 0
                    if (PARITY == 1) begin
                        perr_d = ~(^shift_q ^ maj);
                    end else begin
                        perr_d = ^shift_q ^ maj;
                    end
                end
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (mid) begin
                    if (!maj) begin
                        ferr_d = 1'b1;
                    end
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        state_d = S_WRITE;
                    end
                end
                if (bit_end) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = m_valid && m_ready;
    assign push = (state_q == S_WRITE) && (!full || pop);

    always_comb begin
        overrun_d = (state_q == S_WRITE) && !push;
        wr_d      = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d      = pop ? rd_q + PTR_W'(1) : rd_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= S_IDLE;
            div_q     <= '0;
            tick_q    <= '0;
            smp_q     <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            smp_q     <= smp_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {ferr_q, perr_q, shift_q};
        end
    end

    // Outputs are masked so an empty FIFO presents zeros, not stale storage
    assign head       = mem_q[rd_q];
    assign m_valid    = (count_q != '0);
    assign m_data     = m_valid ? head[DATA_BITS-1:0] : '0;
    assign m_perr     = m_valid & head[DATA_BITS];
    assign m_ferr     = m_valid & head[DATA_BITS+1];
    assign fifo_count = count_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: default-rate, fast-rate and even-parity
// instances driven with directed frames; monitors pop and compare each entry.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int FAST_BAUD = 1_562_500;
    localparam int BT_DEF    = 8680;
    localparam int BT_FAST   = 640;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic m_ready;
    logic rxd_d, rxd_f, rxd_p;

    logic [7:0] d_data, f_data, p_data;
    logic       d_perr, f_perr, p_perr;
    logic       d_ferr, f_ferr, p_ferr;
    logic       d_valid, f_valid, p_valid;
    logic [4:0] d_count, f_count, p_count;
    logic       d_ovr, f_ovr, p_ovr;
    logic       d_busy, f_busy, p_busy;

    uart_rx_fifo u_def (
        .clk(clk), .rst(rst), .rxd(rxd_d),
        .m_data(d_data), .m_perr(d_perr), .m_ferr(d_ferr),
        .m_valid(d_valid), .m_ready(m_ready), .fifo_count(d_count),
        .overrun(d_ovr), .busy(d_busy)
    );

    uart_rx_fifo #(.BAUD_RATE(FAST_BAUD)) u_fast (
        .clk(clk), .rst(rst), .rxd(rxd_f),
        .m_data(f_data), .m_perr(f_perr), .m_ferr(f_ferr),
        .m_valid(f_valid), .m_ready(m_ready), .fifo_count(f_count),
        .overrun(f_ovr), .busy(f_busy)
    );

    uart_rx_fifo #(.BAUD_RATE(FAST_BAUD), .PARITY(2)) u_par (
        .clk(clk), .rst(rst), .rxd(rxd_p),
        .m_data(p_data), .m_perr(p_perr), .m_ferr(p_ferr),
        .m_valid(p_valid), .m_ready(m_ready), .fifo_count(p_count),
        .overrun(p_ovr), .busy(p_busy)
    );

    int   checks = 0;
    int   errors = 0;
    int   ovr_d = 0, ovr_f = 0, ovr_p = 0;
    exp_t q_d[$], q_f[$], q_p[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (d_ovr) ovr_d++;
        if (f_ovr) ovr_f++;
        if (p_ovr) ovr_p++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && m_ready && d_valid) begin
            if (q_d.size() == 0) begin
                chk("def_unexpected", {22'd0, d_data, d_perr, d_ferr}, 32'hFFFF);
            end else begin
                e = q_d.pop_front();
                chk("def_entry", {22'd0, d_data, d_perr, d_ferr}, {22'd0, e});
            end
        end
        if (!rst && m_ready && f_valid) begin
            if (q_f.size() == 0) begin
                chk("fast_unexpected", {22'd0, f_data, f_perr, f_ferr}, 32'hFFFF);
            end else begin
                e = q_f.pop_front();
                chk("fast_entry", {22'd0, f_data, f_perr, f_ferr}, {22'd0, e});
            end
        end
        if (!rst && m_ready && p_valid) begin
            if (q_p.size() == 0) begin
                chk("par_unexpected", {22'd0, p_data, p_perr, p_ferr}, 32'hFFFF);
            end else begin
                e = q_p.pop_front();
                chk("par_entry", {22'd0, p_data, p_perr, p_ferr}, {22'd0, e});
            end
        end
    end

    task automatic drive(input int w, input logic v);
        case (w)
            0: rxd_d = v;
            1: rxd_f = v;
            default: rxd_p = v;
        endcase
    endtask

    // par < 0: no parity bit, otherwise par[0] is the parity bit sent
    task automatic send(input int w, input int bt, input logic [7:0] data,
                        input int par, input logic stopv);
        drive(w, 1'b0);
        #bt;
        for (int i = 0; i < 8; i++) begin
            drive(w, data[i]);
            #bt;
        end
        if (par >= 0) begin
            drive(w, par[0]);
            #bt;
        end
        drive(w, stopv);
        #bt;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 m_ready = v;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_d.size() + q_f.size() + q_p.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, q_d.size() + q_f.size() + q_p.size(), 0);
    endtask

    initial begin
        logic [7:0] bytes [3];
        int n;
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        bytes[2] = 8'h12;
        rst = 1'b1;
        m_ready = 1'b0;
        rxd_d = 1'b1;
        rxd_f = 1'b1;
        rxd_p = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", f_valid, 0);
        chk("rst_count", f_count, 0);
        chk("rst_busy", f_busy, 0);
        chk("rst_ovr", f_ovr, 0);
        chk("rst_data", f_data, 0);
        chk("rst_def_busy", d_busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // 8N1 at default rate
        set_ready(1'b1);
        for (int i = 0; i < 3; i++) begin
            q_d.push_back('{data: bytes[i], perr: 1'b0, ferr: 1'b0});
            send(0, BT_DEF, bytes[i], -1, 1'b1);
        end
        drain("drain_8n1");
        chk("def_overrun", ovr_d, 0);

        // Fill to full, 17th frame dropped
        set_ready(1'b0);
        ovr_f = 0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) q_f.push_back('{data: 8'(i), perr: 1'b0, ferr: 1'b0});
            send(1, BT_FAST, 8'(i), -1, 1'b1);
        end
        #(BT_FAST);
        @(negedge clk);
        chk("full_count", f_count, 16);
        chk("full_overrun", ovr_f, 1);
        set_ready(1'b1);
        n = 0;
        while (f_count != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("empty_count", f_count, 0);
        drain("drain_full");

        // Even parity
        q_p.push_back('{data: 8'h5A, perr: 1'b1, ferr: 1'b0});
        send(2, BT_FAST, 8'h5A, 1, 1'b1);
        q_p.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
        send(2, BT_FAST, 8'h5A, 0, 1'b1);
        drain("drain_par");

        // Framing error then break
        q_f.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
        drive(1, 1'b0);
        #(BT_FAST * 20);
        drive(1, 1'b1);
        #(BT_FAST * 2);
        q_f.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
        send(1, BT_FAST, 8'h3C, -1, 1'b1);
        drain("drain_break");

        // Glitch on idle line
        drive(1, 1'b0);
        #200;
        drive(1, 1'b1);
        #100;
        @(negedge clk);
        chk("glitch_busy_hi", f_busy, 1);
        #(BT_FAST);
        @(negedge clk);
        chk("glitch_busy_lo", f_busy, 0);
        chk("glitch_count", f_count, 0);

        // Reset mid-frame with one entry held
        set_ready(1'b0);
        send(1, BT_FAST, 8'h77, -1, 1'b1);
        #(BT_FAST);
        @(negedge clk);
        chk("pre_rst_count", f_count, 1);
        drive(1, 1'b0);
        #(BT_FAST);
        drive(1, 1'b1);
        #(BT_FAST);
        drive(1, 1'b0);
        #(BT_FAST / 2);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 1'b1);
        @(negedge clk);
        chk("mid_rst_count", f_count, 0);
        chk("mid_rst_valid", f_valid, 0);
        chk("mid_rst_busy", f_busy, 0);
        set_ready(1'b1);
        #(BT_FAST);
        q_f.push_back('{data: 8'h12, perr: 1'b0, ferr: 1'b0});
        send(1, BT_FAST, 8'h12, -1, 1'b1);
        drain("drain_rst");
        chk("par_overrun", ovr_p, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
